// File: rtl/mem_arbiter_pkg.sv
// Shared types for mem_arbiter: FSM states, requester owners, access-size codes.
// Imported by rtl/mem_arbiter.sv.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_e;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  localparam int RAM_DATA_W = 8;

  // Size code 2'b11 is served as a full word.
  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: return 3'd1;
      MEM_SIZE_H: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one RAM port between instruction fetch and the MEM stage.
// Define MEM_ARB_RR_EN for round-robin grants; default build is fixed priority (MEM over IF).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_done,
  output logic [31:0]           if_rdata,
  input  logic                  flush,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_size,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  output logic                  stall_if,
  output logic                  stall_mem,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_wr,
  output logic [RAM_DATA_W-1:0] ram_dout,
  input  logic [RAM_DATA_W-1:0] ram_din,
  output arb_state_e            dbg_state
);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  logic       we_q, we_d;
  logic [2:0] cnt_q, cnt_d, n_q, n_d, cnt_inc;
  logic [1:0] lane;
  logic [ADDR_W-1:0] base_q, base_d, ram_addr_q, ram_addr_d;
  logic [31:0] wdata_q, wdata_d, buf_q, buf_d;
  logic [31:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic        ram_wr_q, ram_wr_d;
  logic [RAM_DATA_W-1:0] ram_dout_q, ram_dout_d;
  logic if_pend, grant_mem, grant_if;

  // Handshake: a requester holds req until its done pulse; done is a 1-cycle pulse
  // in DONE and the requester drops or changes req in the following cycle.
  assign if_pend = if_req & ~flush;
  assign cnt_inc = cnt_q + 3'd1;
  // The byte on ram_din belongs to the address issued one cycle earlier.
  assign lane    = 2'(cnt_q - 3'd1);

`ifdef MEM_ARB_RR_EN
  logic last_mem_q, last_mem_d;
  assign grant_mem = mem_req & (~if_pend | ~last_mem_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_mem_q <= 1'b0;
    else     last_mem_q <= last_mem_d;
  end
`else
  assign grant_mem = mem_req;
`endif
  assign grant_if = if_pend & ~grant_mem;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_q;
`ifdef MEM_ARB_RR_EN
    last_mem_d  = last_mem_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (grant_mem || grant_if) begin
          owner_d    = grant_mem ? OWNER_MEM : OWNER_IF;
          we_d       = grant_mem & mem_we;
          base_d     = grant_mem ? mem_addr : if_addr;
          n_d        = grant_mem ? size_to_n(mem_size) : 3'd4;
          wdata_d    = mem_wdata;
          cnt_d      = 3'd0;
          buf_d      = 32'd0;
          ram_addr_d = base_d;
`ifdef MEM_ARB_RR_EN
          last_mem_d = grant_mem;
`endif
          if (we_d) begin
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
            state_d    = ARB_WR;
          end else begin
            state_d    = ARB_RD;
          end
        end
      end
      ARB_RD: begin
        if (owner_q == OWNER_IF && flush) begin
          state_d = ARB_IDLE;
        end else begin
          if (cnt_q != 3'd0) buf_d[{lane, 3'b000} +: 8] = ram_din;
          if (cnt_q == n_q) begin
            state_d = ARB_DONE;
            if (owner_q == OWNER_IF) if_rdata_d  = buf_d;
            else                     mem_rdata_d = buf_d;
          end else begin
            cnt_d = cnt_inc;
            // The final capture cycle issues nothing and holds ram_addr.
            if (cnt_inc < n_q) ram_addr_d = base_q + ADDR_W'(cnt_inc);
          end
        end
      end
      ARB_WR: begin
        if (cnt_inc < n_q) begin
          ram_wr_d   = 1'b1;
          ram_addr_d = base_q + ADDR_W'(cnt_inc);
          ram_dout_d = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
          cnt_d      = cnt_inc;
        end else begin
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWNER_IF;
      we_q        <= 1'b0;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      base_q      <= '0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
    end
  end

  assign if_done   = (state_q == ARB_DONE) && (owner_q == OWNER_IF);
  assign mem_done  = (state_q == ARB_DONE) && (owner_q == OWNER_MEM);
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign stall_if  = if_req & ~if_done;
  assign stall_mem = mem_req & ~mem_done;
  assign ram_addr  = ram_addr_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte-wide RAM model, write/read-address monitors,
// scoreboard queues of expected load data and store bytes.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, flush, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic        if_done, mem_done, stall_if, stall_mem, ram_wr;
  logic [31:0] if_rdata, mem_rdata, ram_addr;
  logic [7:0]  ram_dout, ram_din;
  arb_state_e  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [39:0] wexp_q[$];
  logic [39:0] wr_obs_q[$];
  logic [31:0] rd_addr_q[$];

  logic [7:0] ram_mem [0:1023];

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / RAM model ----------------
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) ram_mem[i] = 8'(i) ^ 8'hA5;
    ram_mem[10'h100] = 8'h13;
    ram_mem[10'h101] = 8'h05;
    ram_mem[10'h102] = 8'h00;
    ram_mem[10'h103] = 8'h00;
  end

  always @(posedge clk) begin
    ram_din <= ram_mem[ram_addr[9:0]];
    if (ram_wr) ram_mem[ram_addr[9:0]] <= ram_dout;
  end

  always @(negedge clk) begin
    if (ram_wr) wr_obs_q.push_back({ram_addr, ram_dout});
    if (dbg_state == ARB_RD && (rd_addr_q.size() == 0 || rd_addr_q[$] != ram_addr))
      rd_addr_q.push_back(ram_addr);
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] addr, input int n);
    logic [31:0] e, a;
    e = 32'd0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      e[8*i +: 8] = ram_mem[a[9:0]];
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic access(input logic is_mem, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    int n, exp_lat, lat, wr_base;
    logic stall_ok, dn, st;
    logic [31:0] e;
    n = (!is_mem) ? 4 : (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    exp_lat = we ? n + 1 : n + 2;
    wr_base = wr_obs_q.size();
    if (we) begin
      for (int i = 0; i < n; i++) wexp_q.push_back({addr + 32'(i), wdata[8*i +: 8]});
    end else begin
      exp_q.push_back(model_load(addr, n));
    end
    @(posedge clk); #1;
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    lat = -1;
    stall_ok = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      dn = is_mem ? mem_done : if_done;
      st = is_mem ? stall_mem : stall_if;
      if (dn) begin
        lat = k;
        check_eq({tag, "_stall_at_done"}, 64'(st), 64'd0);
        break;
      end
      if (st !== 1'b1) stall_ok = 1'b0;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_stall"}, 64'(stall_ok), 64'd1);
    if (we) begin
      check_eq({tag, "_wr_count"}, 64'(wr_obs_q.size() - wr_base), 64'(n));
      for (int i = 0; i < n; i++) begin
        e = 32'(i);
        if (wr_base + i < wr_obs_q.size())
          check_eq({tag, "_wr_byte"}, 64'(wr_obs_q[wr_base + i]), 64'(wexp_q.pop_front()));
        else
          void'(wexp_q.pop_front());
      end
    end else begin
      e = exp_q.pop_front();
      if (lat >= 0) check_eq({tag, "_rdata"}, 64'(is_mem ? mem_rdata : if_rdata), 64'(e));
    end
    @(posedge clk); #1;
    mem_req = 1'b0;
    if_req  = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int mem_lat, if_lat, wr_base, rd_base, exp_m, exp_i;
    logic [31:0] e_m, e_i, e_f, ra;
    logic early_done;
    logic [1:0] rs;
    logic rw, rm;

    rst = 1'b1; if_req = 1'b0; flush = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    mem_size = 2'b00; if_addr = 32'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    #1;
    check_eq("rst_ram_wr", 64'(ram_wr), 64'd0);
    check_eq("rst_ram_addr", 64'(ram_addr), 64'd0);
    check_eq("rst_ram_dout", 64'(ram_dout), 64'd0);
    check_eq("rst_dones", 64'({if_done, mem_done}), 64'd0);
    check_eq("rst_rdata", 64'({if_rdata, mem_rdata}), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'(ARB_IDLE));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // fetch 0x100 -> 0x00000513, done at T6
    access(1'b0, 1'b0, 2'b10, 32'h100, 32'd0, "fetch");
    check_eq("fetch_insn", 64'(if_rdata), 64'h0000_0513);

    // store word 0xDEADBEEF at 0x2003, done at T5
    access(1'b1, 1'b1, 2'b10, 32'h2003, 32'hDEAD_BEEF, "store_w");

    // simultaneous requests: MEM byte load vs fetch
    e_m = model_load(32'h40, 1);
    e_i = model_load(32'h104, 4);
`ifdef MEM_ARB_RR_EN
    exp_i = 6;  exp_m = 10;
`else
    exp_m = 3;  exp_i = 10;
`endif
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h40;
    if_req = 1'b1; if_addr = 32'h104;
    mem_lat = -1; if_lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_done && mem_lat < 0) begin
        mem_lat = k;
        check_eq("dual_mem_rdata", 64'(mem_rdata), 64'(e_m));
      end
      if (if_done && if_lat < 0) begin
        if_lat = k;
        check_eq("dual_if_rdata", 64'(if_rdata), 64'(e_i));
      end
      if (mem_lat >= 0 && if_lat >= 0) break;
      @(posedge clk); #1;
      if (mem_lat >= 0) mem_req = 1'b0;
      if (if_lat >= 0) if_req = 1'b0;
    end
    @(posedge clk); #1;
    mem_req = 1'b0; if_req = 1'b0;
    check_eq("dual_mem_latency", 64'(mem_lat), 64'(exp_m));
    check_eq("dual_if_latency", 64'(if_lat), 64'(exp_i));

    // flush at T3 of a fetch; refetch at T4 completes at T10
    e_f = model_load(32'h204, 4);
    early_done = 1'b0;
    if_lat = -1;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h200;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 4) check_eq("flush_idle", 64'(dbg_state), 64'(ARB_IDLE));
      if (if_done) begin
        if (k < 4) early_done = 1'b1;
        else begin
          if_lat = k;
          check_eq("flush_refetch_rdata", 64'(if_rdata), 64'(e_f));
          break;
        end
      end
      @(posedge clk); #1;
      if (k == 2) flush = 1'b1;
      if (k == 3) begin flush = 1'b0; if_addr = 32'h204; end
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    check_eq("flush_no_done", 64'(early_done), 64'd0);
    check_eq("flush_refetch_latency", 64'(if_lat), 64'd10);

    // reset after two store bytes
    wr_base = wr_obs_q.size();
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h300; mem_wdata = 32'h1122_3344;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; mem_req = 1'b0;
    #1;
    check_eq("rst_mid_ram_wr", 64'(ram_wr), 64'd0);
    early_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_done) early_done = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_done) early_done = 1'b1;
    end
    check_eq("rst_mid_no_done", 64'(early_done), 64'd0);
    check_eq("rst_mid_wr_count", 64'(wr_obs_q.size() - wr_base), 64'd2);
    if (wr_obs_q.size() - wr_base >= 2) begin
      check_eq("rst_mid_wr0", 64'(wr_obs_q[wr_base]), 64'({32'h300, 8'h44}));
      check_eq("rst_mid_wr1", 64'(wr_obs_q[wr_base + 1]), 64'({32'h301, 8'h33}));
    end
    check_eq("rst_mid_ram_addr", 64'(ram_addr), 64'd0);
    check_eq("rst_mid_rdata", 64'({if_rdata, mem_rdata}), 64'd0);

    // address wrap on a word load
    rd_base = rd_addr_q.size();
    access(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'd0, "wrap");
    check_eq("wrap_addr_count", 64'(rd_addr_q.size() - rd_base), 64'd4);
    if (rd_addr_q.size() - rd_base >= 4) begin
      check_eq("wrap_a0", 64'(rd_addr_q[rd_base]),     64'h0000_0000_FFFF_FFFE);
      check_eq("wrap_a1", 64'(rd_addr_q[rd_base + 1]), 64'h0000_0000_FFFF_FFFF);
      check_eq("wrap_a2", 64'(rd_addr_q[rd_base + 2]), 64'd0);
      check_eq("wrap_a3", 64'(rd_addr_q[rd_base + 3]), 64'd1);
    end

    // random mix of fetches, misaligned loads and stores of every size code
    for (int t = 0; t < 16; t++) begin
      rm = 1'($urandom_range(0, 1));
      rw = rm & 1'($urandom_range(0, 1));
      rs = 2'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 1023));
      access(rm, rw, rs, ra, $urandom, rm ? (rw ? "rnd_store" : "rnd_load") : "rnd_fetch");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
